biquad_feeder: RTL

- Front end of the biquad IIR section. It supplies the sample input, the valid strobe and all five filter coefficients.
- Accepts samples from upstream over a ready/valid handshake and buffers them in a small FIFO.
- Issues samples as single-cycle valid pulses at a programmable spacing, which gives multicycle multipliers their required gap.
- Holds the coefficients in a shadow/active double buffer. The active set changes only between sample issues.

---
 rtl/biquad_feeder_pkg.sv | 17 +
 rtl/biquad_feeder_fifo.sv | 69 ++++++
 rtl/biquad_feeder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/biquad_feeder_pkg.sv
// Shared definitions for the biquad feeder: coefficient select encoding and
// the underrun counter limit.
package biquad_feeder_pkg;

   typedef logic [2:0] coef_sel_t;

   localparam coef_sel_t COEF_A11 = 3'd0;
   localparam coef_sel_t COEF_A12 = 3'd1;
   localparam coef_sel_t COEF_B10 = 3'd2;
   localparam coef_sel_t COEF_B11 = 3'd3;
   localparam coef_sel_t COEF_B12 = 3'd4;

   localparam int NUM_COEF = 5;

   localparam logic [7:0] UNDERRUN_SAT = 8'd255;

endpackage

// File: rtl/biquad_feeder_fifo.sv
// Small synchronous sample FIFO for the biquad feeder. Power-of-two depth,
// pointers wrap naturally; push is refused when full even if popping.
module biquad_feeder_fifo #(
   parameter int W     = 12,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         nreset,
   input  logic                         push,
   input  logic [W-1:0]                 push_data,
   input  logic                         pop,
   output logic [W-1:0]                 pop_data,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/biquad_feeder.sv
// Biquad front end: buffers samples, paces them out as one-cycle strobes and
// double-buffers the coefficients. Optional zero-fill: BIQUAD_FEEDER_UNDERRUN_ZERO_EN.
module biquad_feeder
   import biquad_feeder_pkg::*;
#(
   parameter int DATAWIDTH  = 12,
   parameter int COEFWIDTH  = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int SPACING_W  = 4
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic [DATAWIDTH-1:0]  s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [SPACING_W-1:0]  spacing,
   input  logic                  coef_load,
   input  logic [2:0]            coef_sel,
   input  logic [COEFWIDTH-1:0]  coef_data,
   input  logic                  coef_commit,
   output logic                  commit_pending,
   output logic [DATAWIDTH-1:0]  x,
   output logic                  valid,
   output logic [COEFWIDTH-1:0]  a11,
   output logic [COEFWIDTH-1:0]  a12,
   output logic [COEFWIDTH-1:0]  b10,
   output logic [COEFWIDTH-1:0]  b11,
   output logic [COEFWIDTH-1:0]  b12,
   output logic [7:0]            underrun_cnt
);

   localparam int CNTW = $clog2(FIFO_DEPTH + 1);

   logic                 fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic [DATAWIDTH-1:0] fifo_head;
   logic [CNTW-1:0]      fifo_count;

   logic [SPACING_W-1:0] cnt_q, cnt_d, reload;
   logic [DATAWIDTH-1:0] x_q, x_d;
   logic                 valid_q, valid_d;
   logic                 pend_q, pend_d;
   logic [COEFWIDTH-1:0] shadow_q [NUM_COEF];
   logic [COEFWIDTH-1:0] shadow_d [NUM_COEF];
   logic [COEFWIDTH-1:0] active_q [NUM_COEF];
   logic [COEFWIDTH-1:0] active_d [NUM_COEF];
   logic                 emit, load_ok;

   assign s_ready   = (fifo_count < CNTW'(FIFO_DEPTH));
   assign fifo_push = s_valid && !fifo_full;
   assign fifo_pop  = emit;

   biquad_feeder_fifo #(
      .W     (DATAWIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .nreset    (nreset),
      .push      (fifo_push),
      .push_data (s_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   // A pending swap takes the edge, so no sample can leave alongside it.
   assign emit   = (cnt_q == '0) && !fifo_empty && !pend_q;
   assign reload = (spacing == '0) ? '0 : spacing - SPACING_W'(1);

`ifdef BIQUAD_FEEDER_UNDERRUN_ZERO_EN
   logic       underrun;
   logic [7:0] urun_q, urun_d;

   assign underrun = (cnt_q == '0) && fifo_empty && !pend_q;

   always_comb begin
      urun_d = urun_q;
      if (underrun && (urun_q != UNDERRUN_SAT)) urun_d = urun_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!nreset) urun_q <= '0;
      else         urun_q <= urun_d;
   end

   assign underrun_cnt = urun_q;
`else
   logic underrun;

   assign underrun     = 1'b0;
   assign underrun_cnt = '0;
`endif

   always_comb begin
      x_d     = x_q;
      valid_d = 1'b0;
      cnt_d   = cnt_q;
      if (emit) begin
         x_d     = fifo_head;
         valid_d = 1'b1;
         cnt_d   = reload;
      end else if (underrun) begin
         x_d     = '0;
         valid_d = 1'b1;
         cnt_d   = reload;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - SPACING_W'(1);
      end
   end

   assign load_ok = coef_load && !pend_q;

   // Loads land in the shadow on the commit edge, so they ride the swap.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      pend_d   = pend_q;
      if (pend_q) begin
         active_d = shadow_q;
         pend_d   = 1'b0;
      end else begin
         for (int i = 0; i < NUM_COEF; i++) begin
            if (load_ok && (coef_sel == coef_sel_t'(i))) shadow_d[i] = coef_data;
         end
         pend_d = coef_commit;
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         cnt_q   <= '0;
         x_q     <= '0;
         valid_q <= 1'b0;
         pend_q  <= 1'b0;
         for (int i = 0; i < NUM_COEF; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         cnt_q    <= cnt_d;
         x_q      <= x_d;
         valid_q  <= valid_d;
         pend_q   <= pend_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign x              = x_q;
   assign valid          = valid_q;
   assign commit_pending = pend_q;
   assign a11            = active_q[COEF_A11];
   assign a12            = active_q[COEF_A12];
   assign b10            = active_q[COEF_B10];
   assign b11            = active_q[COEF_B11];
   assign b12            = active_q[COEF_B12];

endmodule
